modexp_pm1: RTL and testbench

//  Modular-exponentiation stage of the Pollard p-1 factoriser; sits directly upstream of GCD.

---
 rtl/modexp_pm1.sv | 178 +++++++++++++++++
 tb/tb_modexp_pm1.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/modexp_pm1.sv
// Modular exponentiation stage for a Pollard p-1 factoriser.
// Computes result = base^exponent mod modulus by left-to-right square-and-multiply.
// Every modular multiply is a bit-serial interleaved shift-add that takes WIDTH cycles.
// result_minus1 = (result - 1) mod modulus is also presented, ready for the downstream GCD.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high; returns to idle and clears all outputs
//   start          one-cycle request, accepted only when idle or done
//   base           any value; reduced mod modulus internally
//   exponent       exponent, scanned MSB first with no leading-zero skipping
//   modulus        n, must be >= 2 (otherwise error is flagged)
//   result         base^exponent mod modulus
//   result_minus1  result-1, or modulus-1 when result is 0
//   busy           high while a job is running
//   done           level, high from completion until the next accepted start or reset
//   error          set together with done when modulus < 2
module modexp_pm1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_minus1,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [2:0] {StIdle, StReduce, StSquare, StMult, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] base_q, exp_q, mod_q;
  logic [WIDTH-1:0] acc_q;   // running mulmod accumulator
  logic [WIDTH-1:0] r_q;     // exponentiation result so far
  logic [WIDTH-1:0] rb_q;    // base mod n
  logic [CW-1:0]    cnt_q;   // cycle within the current mulmod
  logic [CW-1:0]    idx_q;   // exponent bit index

  logic             last;
  logic             err_hit;
  logic [WIDTH-1:0] mul_x, mul_y, acc_next, rm1_next;
  logic [CW-1:0]    bit_sel;
  logic             y_bit;
  logic [WIDTH:0]   t_dbl, t_red1, t_add, t_red2;

  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign err_hit = (state_q == StReduce) && (cnt_q == '0) && (mod_q < WIDTH'(2));

  // Operand selection for the shared mulmod datapath.
  always_comb begin
    mul_x = r_q;
    mul_y = r_q;
    unique case (state_q)
      StReduce: begin
        mul_x = WIDTH'(1);
        mul_y = base_q;
      end
      StMult:   mul_y = rb_q;
      default:  ;
    endcase
  end

  // One interleaved shift-add step; acc stays < n so WIDTH+1 bits never overflow.
  always_comb begin
    bit_sel  = CW'(WIDTH - 1) - cnt_q;
    y_bit    = mul_y[bit_sel];
    t_dbl    = {acc_q, 1'b0};
    t_red1   = (t_dbl >= {1'b0, mod_q}) ? t_dbl - {1'b0, mod_q} : t_dbl;
    t_add    = y_bit ? t_red1 + {1'b0, mul_x} : t_red1;
    t_red2   = (t_add >= {1'b0, mod_q}) ? t_add - {1'b0, mod_q} : t_add;
    acc_next = t_red2[WIDTH-1:0];
    rm1_next = (acc_next == '0) ? mod_q - WIDTH'(1) : acc_next - WIDTH'(1);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StReduce;
      StReduce: begin
        if (err_hit)   state_d = StDone;
        else if (last) state_d = StSquare;
      end
      StSquare: begin
        if (last) begin
          if (exp_q[idx_q])      state_d = StMult;
          else if (idx_q == '0) state_d = StDone;
          else                   state_d = StSquare;
        end
      end
      StMult: begin
        if (last) state_d = (idx_q == '0) ? StDone : StSquare;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      base_q        <= '0;
      exp_q         <= '0;
      mod_q         <= '0;
      acc_q         <= '0;
      r_q           <= '0;
      rb_q          <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      result        <= '0;
      result_minus1 <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            base_q <= base;
            exp_q  <= exponent;
            mod_q  <= modulus;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
            error  <= 1'b0;
          end
        end
        StReduce: begin
          if (err_hit) begin
            result        <= '0;
            result_minus1 <= '0;
            busy          <= 1'b0;
            done          <= 1'b1;
            error         <= 1'b1;
          end else if (last) begin
            rb_q  <= acc_next;
            r_q   <= WIDTH'(1);
            idx_q <= CW'(WIDTH - 1);
            acc_q <= '0;
            cnt_q <= '0;
          end else begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StSquare, StMult: begin
          if (last) begin
            r_q   <= acc_next;
            acc_q <= '0;
            cnt_q <= '0;
            if (state_d == StDone) begin
              result        <= acc_next;
              result_minus1 <= rm1_next;
              busy          <= 1'b0;
              done          <= 1'b1;
            end else if (state_d == StSquare) begin
              idx_q <= idx_q - CW'(1);
            end
          end else begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_pm1.sv
module tb_modexp_pm1;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] base, exponent, modulus;
  logic [31:0] result, result_minus1;
  logic        busy, done, error;

  int n_cmp = 0;
  int n_err = 0;

  modexp_pm1 #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base          (base),
    .exponent      (exponent),
    .modulus       (modulus),
    .result        (result),
    .result_minus1 (result_minus1),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  // Right-to-left binary exponentiation with native 64-bit arithmetic.
  function automatic longint unsigned ref_pow(longint unsigned b, longint unsigned e,
                                              longint unsigned m);
    longint unsigned r, bb;
    r  = 1 % m;
    bb = b % m;
    while (e != 0) begin
      if (e[0]) r = (r * bb) % m;
      bb = (bb * bb) % m;
      e  = e >> 1;
    end
    return r;
  endfunction

  function automatic longint unsigned gcd(longint unsigned a, longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start with the given operands; returns #1 after the accepting edge.
  task automatic launch(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    @(negedge clk);
    base = b; exponent = e; modulus = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen; lat = -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_job(input string tag, input logic [31:0] b, input logic [31:0] e,
                         input logic [31:0] m);
    longint unsigned exp_r, exp_rm1;
    int lat, exp_lat;
    bit exp_err;
    exp_err = (m < 2);
    if (exp_err) begin
      exp_r = 0; exp_rm1 = 0; exp_lat = 1;
    end else begin
      exp_r   = ref_pow(b, e, m);
      exp_rm1 = (exp_r == 0) ? m - 1 : exp_r - 1;
      exp_lat = 32 * (1 + 32 + $countones(e));
    end
    launch(b, e, m);
    chk({tag, ".busy_after_start"}, busy, 1);
    chk({tag, ".done_cleared"}, done, 0);
    wait_done(lat);
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".result"}, result, exp_r);
    chk({tag, ".result_minus1"}, result_minus1, exp_rm1);
    chk({tag, ".error"}, error, exp_err);
    chk({tag, ".busy_at_done"}, busy, 0);
  endtask

  initial begin
    int lat;
    logic [31:0] rb, re, rm;
    reset = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.result", result, 0);
    chk("reset.result_minus1", result_minus1, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.error", error, 0);
    @(negedge clk);
    reset = 1'b0;

    run_job("t1", 32'd3, 32'd5, 32'd7);
    chk("t1.result_const", result, 5);
    run_job("t2", 32'd2, 32'd12, 32'd299);
    chk("t2.gcd", gcd(result_minus1, 299), 13);
    run_job("t3a", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB);
    chk("t3a.result_const", result, 16);
    run_job("t3b", 32'd100, 32'd1, 32'd7);
    chk("t3b.result_const", result, 2);
    run_job("t4_exp0", 32'd9, 32'd0, 32'd11);
    run_job("t4_base0", 32'd22, 32'd7, 32'd11);
    run_job("t4_mod1", 32'd5, 32'd3, 32'd1);
    run_job("t4_mod0", 32'd5, 32'd3, 32'd0);
    run_job("t4_allones", 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Start pulsed mid-job with different operands must be ignored.
    launch(32'd3, 32'd5, 32'd7);
    repeat (100) @(posedge clk);
    @(negedge clk);
    base = 32'd2; exponent = 32'd12; modulus = 32'd299; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    chk("t5.busy_start.latency", (lat < 0) ? -1 : lat + 101, 1120);
    chk("t5.busy_start.result", result, 5);
    chk("t5.busy_start.result_minus1", result_minus1, 4);

    // Reset in the middle of a job discards it.
    launch(32'd2, 32'd12, 32'd299);
    repeat (499) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t5.rst.result", result, 0);
    chk("t5.rst.result_minus1", result_minus1, 0);
    chk("t5.rst.busy", busy, 0);
    chk("t5.rst.done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("t5.rst.stays_idle", {busy, done}, 0);
    run_job("t5.after_rst", 32'd3, 32'd5, 32'd7);

    // Random operands against the reference model.
    for (int k = 0; k < 8; k++) begin
      rb = $urandom;
      re = (k < 4) ? $urandom_range(0, 4095) : $urandom;
      rm = (k[0]) ? $urandom : $urandom_range(2, 1000);
      if (rm < 2) rm = 2;
      run_job($sformatf("rand%0d", k), rb, re, rm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
